// File: rtl/pc_bus_reader_pkg.sv
// Shared definitions for the program-counter fetch reader.
// Holds the default address width, the reset fetch vector, the fetch FSM
// state encoding and the prefetch buffer entry layout.
package pc_bus_reader_pkg;

    localparam int PC_ADDR_W = 16;

    // Fetch pointer value after reset; the core's vector fetch starts here.
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } pcbr_state_t;

    // One prefetched byte together with the address it was read from.
    typedef struct packed {
        logic [PC_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } pcbr_entry_t;

endpackage

// File: rtl/pc_bus_reader_fifo.sv
// Purpose : DEPTH-entry first-word-fall-through buffer for prefetched bytes.
// Latency : a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: the caller never pushes when full; flush has priority over push and pop.
// Ports   : clk/rst (async active-high), push/wr_data, pop, flush,
//           rd_data (head entry), count, full, empty.
module pcbr_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/pc_bus_reader.sv
// Purpose : drives the fetch address bus, runs RDY-handshaked reads and queues bytes for decode.
// Latency : load -> A/rd_req next edge; a byte completed with RDY is at the buffer head one edge later.
// Backpressure: reads pause (HOLD) while the prefetch buffer is full, resume right after a pop.
// Ports   : PHI2 clock, RES async active-high reset; load/load_addr redirect the fetch pointer;
//           A/rd_req/RDY/D external read bus; out_valid/out_ready/out_data/out_addr decode side;
//           bus_err one-cycle pulse when a read waits too long.
module pc_bus_reader
    import pc_bus_reader_pkg::*;
#(
    parameter int ADDR_W     = PC_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              PHI2,
    input  logic              RES,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] A,
    output logic              rd_req,
    input  logic              RDY,
    input  logic [7:0]        D,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WC_W  = $clog2(WAIT_LIMIT + 1);
    localparam int ENT_W = ADDR_W + 8;

    pcbr_state_t       state;
    pcbr_state_t       next_state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [WC_W-1:0]   wait_cnt;

    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    pcbr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (PHI2),
        .rst     (RES),
        .push    (push),
        .wr_data ({fetch_pc, D}),
        .pop     (pop),
        .flush   (load),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = ~empty;
    assign out_addr  = head[ENT_W-1:8];
    assign out_data  = head[7:0];
    assign A         = fetch_pc;

    always_comb begin
        next_state = state;
        push       = 1'b0;
        // A load flushes the buffer, so a simultaneous pop is meaningless.
        pop        = out_valid & out_ready & ~load;

        unique case (state)
            IDLE: begin
                next_state = IDLE;
            end
            REQ: begin
                if (RDY) begin
                    push = ~load;
                    // Leave REQ when this push fills the buffer, so a push
                    // is never attempted against a full buffer.
                    if ((count == CNT_W'(DEPTH - 1)) && !pop) begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!full || pop) begin
                    next_state = REQ;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (load) begin
            next_state = REQ;
        end
    end

    always_ff @(posedge PHI2 or posedge RES) begin
        if (RES) begin
            state    <= IDLE;
            rd_req   <= 1'b0;
            fetch_pc <= ADDR_W'(RESET_VECTOR);
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state   <= next_state;
            rd_req  <= (next_state == REQ);
            bus_err <= 1'b0;
            if (load) begin
                fetch_pc <= load_addr;
                wait_cnt <= '0;
            end else if (state == REQ) begin
                if (RDY) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                    wait_cnt <= '0;
                end else if (wait_cnt == WC_W'(WAIT_LIMIT - 1)) begin
                    // WAIT_LIMIT-th stalled cycle: flag it and keep the read pending.
                    bus_err  <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WC_W'(1);
                end
            end
        end
    end

endmodule
